wbu_writer: RTL and testbench
=============================

Name: wbu_writer

Overview:
- Writeback-stage writer that drives the register-file write port (RFwe, rdaddr, rd, wb_valid).
- Accepts completed results from two producers, EXU (ALU/branch-link) and LSU (loads), over valid/ready handshakes.
- Arbitrates between the two producers, extracts and extends load data, and registers one write per cycle.
- Also keeps a 64-bit retired-instruction counter.

Parameters:
- XLEN, 64, datapath width.
- STARVE_MAX, 4, consecutive EXU-blocked cycles before EXU gets forced priority.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- exu_valid  in  1  EXU result valid
- exu_ready  out  1  EXU result accepted this cycle
- exu_wen  in  1  EXU result writes a register
- exu_rdaddr  in  5  EXU destination register
- exu_result  in  XLEN  EXU result
- lsu_valid  in  1  LSU load result valid
- lsu_ready  out  1  LSU result accepted this cycle
- lsu_rdaddr  in  5  load destination register
- lsu_rdata  in  XLEN  raw aligned 64-bit memory word
- lsu_offset  in  3  byte offset within the word
- lsu_size  in  2  access size: 0=B, 1=H, 2=W, 3=D
- lsu_unsigned  in  1  zero-extend when 1, sign-extend when 0
- RFwe  out  1  register-file write enable
- rdaddr  out  5  register-file write address
- rd  out  XLEN  register-file write data
- wb_valid  out  1  an instruction retired this cycle
- instret  out  64  retired-instruction count
- byp_valid / byp_addr / byp_data  out  1/5/XLEN  forwarding to IDU (optional feature)

Behaviour:
- Reset: on rst at posedge clk, the following are all cleared to 0:
  - RFwe, rdaddr, rd, wb_valid, instret, byp_*
  - the starvation counter
  - the priority flag
- Reset has priority over any in-flight handshake. A result presented during reset is dropped, not accepted.
- Latency:
  - Accept in cycle N; RFwe, rdaddr, rd and wb_valid are valid in cycle N+1 for exactly one cycle.
  - Full throughput: one retirement per cycle.
- Handshake:
  - At most one of exu_ready or lsu_ready is high per cycle.
  - A ready is high only when the matching valid is high and that source wins arbitration (ready depends combinationally on valid).
  - A source holds valid and its payload stable until accepted.
- Arbitration state machine:
  - States NORMAL and EXU_PRIO.
  - NORMAL: LSU wins whenever lsu_valid is high.
  - Every cycle with exu_valid high and EXU not accepted increments the starvation counter. The counter saturates at STARVE_MAX. It clears to 0 on any EXU accept.
  - When the counter equals STARVE_MAX, move to EXU_PRIO. In EXU_PRIO, EXU wins the next cycle it is valid, then the block returns to NORMAL.
- Load extraction:
  - Shift lsu_rdata right by lsu_offset*8.
  - Take the low 8, 16, 32 or 64 bits according to lsu_size.
  - Sign- or zero-extend to XLEN. Size D ignores lsu_unsigned.
  - Misaligned combinations (offset not a multiple of the size) are the LSU's responsibility: the block extracts as specified, with bits above bit 63 read as 0.
- Write rules:
  - RFwe = accepted AND wen AND rdaddr != 0. LSU results always have wen = 1.
  - wb_valid = accepted, regardless of wen or x0.
  - A write to x0 retires but never asserts RFwe.
- instret:
  - Increments by 1 in the cycle wb_valid is high.
  - Wraps modulo 2^64.
- Idle cycles (neither source valid): RFwe=0 and wb_valid=0. rdaddr and rd hold their last values.

Optional Feature:
- Macro: WBU_BYPASS_EN.
- Defined:
  - byp_valid = RFwe, and byp_addr / byp_data mirror rdaddr / rd in the same cycle.
  - This lets the IDU forward over the registered register-file read.
- Undefined: byp_valid, byp_addr and byp_data are tied to 0, with no added logic.

Decomposition:
- Shared package wbu_pkg holds:
  - the XLEN constant
  - the size enum (SZ_B, SZ_H, SZ_W, SZ_D)
  - the arbitration-state enum (NORMAL, EXU_PRIO)
- Natural sub-module: wbu_load_ext, a combinational extractor/extender with inputs (rdata, offset, size, unsigned) and output data.

Test Plan:
- Reset: hold rst 2 cycles with both sources valid -> no ready asserted; all outputs 0; instret=0.
- EXU only: exu_rdaddr=5, exu_result=0xDEAD, exu_wen=1 -> next cycle RFwe=1, rdaddr=5, rd=0xDEAD, wb_valid=1, instret=1.
- Load extension: lsu_rdata=0x00000000_80FF0000, offset=2, size=B, signed -> rd=0xFFFF_FFFF_FFFF_FFFF; same stimulus with unsigned -> rd=0xFF; size=H, offset=2, signed -> rd=0xFFFF_FFFF_FFFF_80FF.
- x0 write: exu_rdaddr=0, wen=1 -> wb_valid=1, RFwe=0, instret increments.
- Starvation: both sources valid continuously -> LSU accepted 4 cycles, EXU accepted 5th cycle, LSU again the 6th.
- Bypass, with WBU_BYPASS_EN defined -> byp_* equal RFwe/rdaddr/rd each cycle; with it undefined -> byp_* remain 0.

Source files
------------

// File: rtl/wbu_pkg.sv
// Shared constants and enums for the writeback-stage writer.
package wbu_pkg;

  localparam int XLEN       = 64;
  localparam int STARVE_MAX = 4;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic {
    NORMAL   = 1'b0,
    EXU_PRIO = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wbu_load_ext.sv
// Combinational load-data extractor: byte-shift the raw word, pick the access size, extend.
module wbu_load_ext
  import wbu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [63:0]  rdata,
  input  logic [2:0]   offset,
  input  size_e        size,
  input  logic         is_unsigned,
  output logic [W-1:0] data
);

  logic [63:0] shifted;
  logic        sext;

  // Bytes shifted in from above bit 63 are zero, which covers misaligned accesses.
  assign shifted = rdata >> {offset, 3'b000};
  assign sext    = ~is_unsigned;

  always_comb begin
    data = '0;
    case (size)
      SZ_B: data = {{(W-8){sext & shifted[7]}}, shifted[7:0]};
      SZ_H: data = {{(W-16){sext & shifted[15]}}, shifted[15:0]};
      SZ_W: data = {{(W-32){sext & shifted[31]}}, shifted[31:0]};
      SZ_D: data = W'(shifted);
    endcase
  end

endmodule

// File: rtl/wbu_writer.sv
// Writeback writer: arbitrates EXU/LSU results, registers one RF write per cycle, counts retirements.
// Optional forwarding port enabled by defining WBU_BYPASS_EN.
//   state    | meaning
//   NORMAL   | LSU wins whenever it is valid
//   EXU_PRIO | EXU starved STARVE_MAX cycles; EXU wins its next valid cycle
module wbu_writer
  import wbu_pkg::*;
#(
  parameter int XLEN       = wbu_pkg::XLEN,
  parameter int STARVE_MAX = wbu_pkg::STARVE_MAX
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic            exu_wen,
  input  logic [4:0]      exu_rdaddr,
  input  logic [XLEN-1:0] exu_result,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rdaddr,
  input  logic [63:0]     lsu_rdata,
  input  logic [2:0]      lsu_offset,
  input  logic [1:0]      lsu_size,
  input  logic            lsu_unsigned,
  output logic            RFwe,
  output logic [4:0]      rdaddr,
  output logic [XLEN-1:0] rd,
  output logic            wb_valid,
  output logic [63:0]     instret,
  output logic            byp_valid,
  output logic [4:0]      byp_addr,
  output logic [XLEN-1:0] byp_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  arb_state_e      state_q, state_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            exu_win;
  logic [XLEN-1:0] load_data;

  wbu_load_ext #(.W(XLEN)) u_load_ext (
    .rdata       (lsu_rdata),
    .offset      (lsu_offset),
    .size        (size_e'(lsu_size)),
    .is_unsigned (lsu_unsigned),
    .data        (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // The state flips as the counter reaches the limit, so priority takes effect the very next cycle.
  always_comb begin
    exu_win   = exu_valid & (~lsu_valid | (state_q == EXU_PRIO));
    exu_ready = ~rst & exu_win;
    lsu_ready = ~rst & lsu_valid & ~exu_win;
    starve_d  = starve_q;
    state_d   = state_q;
    if (exu_ready) begin
      starve_d = '0;
      state_d  = NORMAL;
    end else if (exu_valid && starve_q != STARVE_LIM) begin
      starve_d = starve_q + 1'b1;
    end
    if (!exu_ready && starve_d == STARVE_LIM) state_d = EXU_PRIO;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RFwe     <= 1'b0;
      rdaddr   <= '0;
      rd       <= '0;
      wb_valid <= 1'b0;
      instret  <= '0;
    end else begin
      wb_valid <= exu_ready | lsu_ready;
      RFwe     <= exu_ready ? (exu_wen && exu_rdaddr != 5'd0)
                            : (lsu_ready && lsu_rdaddr != 5'd0);
      if (exu_ready) begin
        rdaddr <= exu_rdaddr;
        rd     <= exu_result;
      end else if (lsu_ready) begin
        rdaddr <= lsu_rdaddr;
        rd     <= load_data;
      end
      if (exu_ready | lsu_ready) instret <= instret + 64'd1;
    end
  end

`ifdef WBU_BYPASS_EN
  assign byp_valid = RFwe;
  assign byp_addr  = rdaddr;
  assign byp_data  = rd;
`else
  assign byp_valid = 1'b0;
  assign byp_addr  = '0;
  assign byp_data  = '0;
`endif

endmodule

// File: tb/tb_wbu_writer.sv
// Self-checking bench for wbu_writer: directed literals plus randomized traffic against a behavioural model.
module tb_wbu_writer;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exu_valid = 1'b0, exu_ready, exu_wen = 1'b0;
  logic [4:0]  exu_rdaddr = '0;
  logic [63:0] exu_result = '0;
  logic        lsu_valid = 1'b0, lsu_ready, lsu_unsigned = 1'b0;
  logic [4:0]  lsu_rdaddr = '0;
  logic [63:0] lsu_rdata = '0;
  logic [2:0]  lsu_offset = '0;
  logic [1:0]  lsu_size = '0;
  logic        RFwe, wb_valid, byp_valid;
  logic [4:0]  rdaddr, byp_addr;
  logic [63:0] rd, instret, byp_data;

  int checks = 0;
  int errors = 0;

  wbu_writer dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
    .exu_rdaddr(exu_rdaddr), .exu_result(exu_result),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rdaddr(lsu_rdaddr),
    .lsu_rdata(lsu_rdata), .lsu_offset(lsu_offset), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned),
    .RFwe(RFwe), .rdaddr(rdaddr), .rd(rd), .wb_valid(wb_valid), .instret(instret),
    .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-wise load model: gather size bytes starting at offset, then extend.
  function automatic logic [63:0] load_model(input logic [63:0] w, input int off, input int sz,
                                             input bit uns);
    int n;
    logic [63:0] r;
    n = 1 << sz;
    r = '0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) r[i*8 +: 8] = w[(off+i)*8 +: 8];
    if (!uns && sz != 3 && r[n*8-1])
      for (int i = n*8; i < 64; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Model state: expected registered outputs and the EXU starvation bookkeeping.
  logic        m_we = 0, m_wb = 0;
  logic [4:0]  m_addr = '0;
  logic [63:0] m_rd = '0, m_instret = '0;
  int          m_starved = 0;
  bit          m_owed = 0;
  bit          e_win, l_win;

  always @(negedge clk) begin
    chk("RFwe", 64'(RFwe), 64'(m_we));
    chk("wb_valid", 64'(wb_valid), 64'(m_wb));
    chk("rdaddr", 64'(rdaddr), 64'(m_addr));
    chk("rd", rd, m_rd);
    chk("instret", instret, m_instret);
`ifdef WBU_BYPASS_EN
    chk("byp_valid", 64'(byp_valid), 64'(m_we));
    chk("byp_addr", 64'(byp_addr), 64'(m_addr));
    chk("byp_data", byp_data, m_rd);
`else
    chk("byp_valid", 64'(byp_valid), 64'd0);
    chk("byp_addr", 64'(byp_addr), 64'd0);
    chk("byp_data", byp_data, 64'd0);
`endif
    e_win = !rst && exu_valid && (!lsu_valid || m_owed);
    l_win = !rst && lsu_valid && !e_win;
    chk("exu_ready", 64'(exu_ready), 64'(e_win));
    chk("lsu_ready", 64'(lsu_ready), 64'(l_win));
    if (rst) begin
      m_we = 0; m_wb = 0; m_addr = '0; m_rd = '0; m_instret = '0;
      m_starved = 0; m_owed = 0;
    end else begin
      m_wb = e_win || l_win;
      m_we = 0;
      if (e_win) begin
        m_we = exu_wen && exu_rdaddr != 0;
        m_addr = exu_rdaddr;
        m_rd = exu_result;
        m_starved = 0;
        m_owed = 0;
      end else begin
        if (l_win) begin
          m_we = lsu_rdaddr != 0;
          m_addr = lsu_rdaddr;
          m_rd = load_model(lsu_rdata, int'(lsu_offset), int'(lsu_size), lsu_unsigned);
        end
        if (exu_valid && m_starved < STARVE) m_starved++;
        if (m_starved == STARVE) m_owed = 1;
      end
      if (m_wb) m_instret = m_instret + 64'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_exu(input logic [4:0] a, input logic [63:0] r, input logic w);
    exu_valid = 1; exu_rdaddr = a; exu_result = r; exu_wen = w; lsu_valid = 0;
    step();
    exu_valid = 0;
  endtask

  task automatic do_lsu(input logic [4:0] a, input logic [63:0] d, input logic [2:0] o,
                        input logic [1:0] s, input logic u);
    lsu_valid = 1; lsu_rdaddr = a; lsu_rdata = d; lsu_offset = o; lsu_size = s;
    lsu_unsigned = u; exu_valid = 0;
    step();
    lsu_valid = 0;
  endtask

  logic ea, la;

  initial begin
    exu_valid = 1; lsu_valid = 1; exu_rdaddr = 5'd7; exu_result = 64'h1234; exu_wen = 1;
    lsu_rdaddr = 5'd9;
    step();
    step();
    chk("reset_rd", rd, 64'd0);
    chk("reset_instret", instret, 64'd0);
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    rst = 0; exu_valid = 0; lsu_valid = 0;
    step();

    do_exu(5'd5, 64'hDEAD, 1'b1);
    chk("exu_RFwe", 64'(RFwe), 64'd1);
    chk("exu_rdaddr", 64'(rdaddr), 64'd5);
    chk("exu_rd", rd, 64'hDEAD);
    chk("exu_instret", instret, 64'd1);

    do_lsu(5'd3, 64'h00000000_80FF0000, 3'd2, 2'd0, 1'b0);
    chk("lb_signed", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    do_lsu(5'd3, 64'h00000000_80FF0000, 3'd2, 2'd0, 1'b1);
    chk("lb_unsigned", rd, 64'h0000_0000_0000_00FF);
    do_lsu(5'd4, 64'h00000000_80FF0000, 3'd2, 2'd1, 1'b0);
    chk("lh_signed", rd, 64'hFFFF_FFFF_FFFF_80FF);

    do_exu(5'd0, 64'h55, 1'b1);
    chk("x0_wb_valid", 64'(wb_valid), 64'd1);
    chk("x0_RFwe", 64'(RFwe), 64'd0);
    chk("x0_instret", instret, 64'd5);

    exu_valid = 1; exu_rdaddr = 5'd10; exu_result = 64'hE; exu_wen = 1;
    lsu_valid = 1; lsu_rdaddr = 5'd11; lsu_rdata = 64'h77; lsu_offset = 0; lsu_size = 2'd3;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("starve_exu_c%0d", c + 1), 64'(exu_ready), (c == 4) ? 64'd1 : 64'd0);
      chk($sformatf("starve_lsu_c%0d", c + 1), 64'(lsu_ready), (c == 4) ? 64'd0 : 64'd1);
      step();
    end
    chk("starve_instret", instret, 64'd11);
    exu_valid = 0; lsu_valid = 0;
    step();

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ea = exu_ready; la = lsu_ready;
      step();
      rst = ($urandom_range(199) == 0);
      if (!exu_valid || ea) begin
        exu_valid  = ($urandom_range(99) < 60);
        exu_wen    = ($urandom_range(3) != 0);
        exu_rdaddr = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
        exu_result = {$urandom, $urandom};
      end
      if (!lsu_valid || la) begin
        lsu_valid    = ($urandom_range(99) < 70);
        lsu_rdaddr   = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
        lsu_rdata    = {$urandom, $urandom};
        lsu_offset   = 3'($urandom_range(7));
        lsu_size     = 2'($urandom_range(3));
        lsu_unsigned = 1'($urandom_range(1));
      end
    end
    rst = 0; exu_valid = 0; lsu_valid = 0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
